// File: rtl/ladowanie_danych_pkg.sv
// ladowanie_pkg: loader FSM states, block size limits and header field widths
package ladowanie_pkg;
    typedef enum logic [2:0] {
        IDLE, WSP_HDR, WSP_DATA, PROB_HDR, PROB_DATA, START_FIR, WAIT_DONE, ERR
    } stan_t;
    localparam int WSP_MAX = 32;
    localparam int PROB_MAX = 8192;
    localparam int WSP_HDR_W = 6;
    localparam int PROB_HDR_W = 14;
endpackage

// File: rtl/ladowanie_danych_if.sv
// ladowanie_danych_if: valid/ready host word stream feeding the loader
interface ladowanie_danych_if #(parameter int DATA_WIDTH = 16);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    modport master (output in_valid, output in_data, input in_ready);
    modport slave (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ladowanie_danych_licznik_adresu.sv
// licznik_adresu: RAM write address counter with clear, enable and terminal-count flag
module licznik_adresu #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] lim,
    output logic [W-1:0] adr,
    output logic         last
);
    logic [W-1:0] adr_d, adr_q;
    // holds at the terminal count so a full 2^W block never rolls over
    always_comb adr_d = clr ? '0 : (en && !last) ? adr_q + W'(1) : adr_q;
    always_ff @(posedge clk) begin
        if (rst) adr_q <= '0;
        else adr_q <= adr_d;
    end
    assign adr = adr_q;
    assign last = adr_q == lim;
endmodule

// File: rtl/ladowanie_danych.sv
// ladowanie_danych: loads FIR coefficients and samples from a host stream, then starts the FIR
module ladowanie_danych
    import ladowanie_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int WSP_ADDR_W  = 5,
    parameter int PROB_ADDR_W = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    ladowanie_danych_if.slave      bus,
    output logic                   wsp_wr,
    output logic [WSP_ADDR_W-1:0]  wsp_adres,
    output logic [DATA_WIDTH-1:0]  wsp_dane,
    output logic                   probki_wr,
    output logic [PROB_ADDR_W-1:0] probki_adres,
    output logic [DATA_WIDTH-1:0]  probki_dane,
    output logic [WSP_HDR_W-1:0]   wsp,
    output logic [PROB_HDR_W-1:0]  ile_probek,
    output logic                   START,
    input  logic                   DONE,
    output logic                   zajety,
    output logic                   blad,
    input  logic                   blad_kasuj
);
    stan_t st_d, st_q;
    logic acc, clr, en, last, n_ok, m_ok;
    logic [PROB_ADDR_W-1:0] adr, lim;
    logic [WSP_HDR_W-1:0] n, wsp_d, wsp_q;
    logic [PROB_HDR_W-1:0] m, ile_d, ile_q;
    logic wsp_wr_d, wsp_wr_q, probki_wr_d, probki_wr_q;
    logic [WSP_ADDR_W-1:0] wsp_adres_d, wsp_adres_q;
    logic [PROB_ADDR_W-1:0] probki_adres_d, probki_adres_q;
    logic [DATA_WIDTH-1:0] wsp_dane_d, wsp_dane_q, probki_dane_d, probki_dane_q;

    assign bus.in_ready = st_q inside {WSP_HDR, WSP_DATA, PROB_HDR, PROB_DATA};
    assign acc = bus.in_valid && bus.in_ready;
    assign n = bus.in_data[WSP_HDR_W-1:0];
    assign m = bus.in_data[PROB_HDR_W-1:0];
    assign n_ok = n != '0 && int'(n) <= WSP_MAX;
    assign m_ok = m != '0 && int'(m) <= PROB_MAX;
    assign lim = st_q == WSP_DATA ? PROB_ADDR_W'(wsp_q) - PROB_ADDR_W'(1)
                                  : PROB_ADDR_W'(ile_q - PROB_HDR_W'(1));

    licznik_adresu #(.W(PROB_ADDR_W)) u_licznik (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .lim(lim), .adr(adr), .last(last)
    );

    always_comb begin
        st_d = st_q;
        clr = 1'b0;
        en = 1'b0;
        wsp_d = wsp_q;
        ile_d = ile_q;
        wsp_wr_d = 1'b0;
        probki_wr_d = 1'b0;
        wsp_adres_d = wsp_adres_q;
        wsp_dane_d = wsp_dane_q;
        probki_adres_d = probki_adres_q;
        probki_dane_d = probki_dane_q;
        case (st_q)
            IDLE: st_d = bus.in_valid ? WSP_HDR : IDLE;
            WSP_HDR: if (acc) begin
                st_d = n_ok ? WSP_DATA : ERR;
                wsp_d = n_ok ? n : wsp_q;
                clr = 1'b1;
            end
            WSP_DATA: if (acc) begin
                en = 1'b1;
                wsp_wr_d = 1'b1;
                wsp_adres_d = WSP_ADDR_W'(adr);
                wsp_dane_d = bus.in_data;
                st_d = last ? PROB_HDR : WSP_DATA;
            end
            PROB_HDR: if (acc) begin
                st_d = m_ok ? PROB_DATA : ERR;
                ile_d = m_ok ? m : ile_q;
                clr = 1'b1;
            end
            PROB_DATA: if (acc) begin
                en = 1'b1;
                probki_wr_d = 1'b1;
                probki_adres_d = adr;
                probki_dane_d = bus.in_data;
                st_d = last ? START_FIR : PROB_DATA;
            end
            START_FIR: st_d = WAIT_DONE;
            WAIT_DONE: st_d = DONE ? IDLE : WAIT_DONE;
            ERR: st_d = blad_kasuj ? IDLE : ERR;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= IDLE;
            wsp_q <= '0;
            ile_q <= '0;
            wsp_wr_q <= 1'b0;
            probki_wr_q <= 1'b0;
            wsp_adres_q <= '0;
            wsp_dane_q <= '0;
            probki_adres_q <= '0;
            probki_dane_q <= '0;
        end else begin
            st_q <= st_d;
            wsp_q <= wsp_d;
            ile_q <= ile_d;
            wsp_wr_q <= wsp_wr_d;
            probki_wr_q <= probki_wr_d;
            wsp_adres_q <= wsp_adres_d;
            wsp_dane_q <= wsp_dane_d;
            probki_adres_q <= probki_adres_d;
            probki_dane_q <= probki_dane_d;
        end
    end

    assign wsp = wsp_q;
    assign ile_probek = ile_q;
    assign wsp_wr = wsp_wr_q;
    assign wsp_adres = wsp_adres_q;
    assign wsp_dane = wsp_dane_q;
    assign probki_wr = probki_wr_q;
    assign probki_adres = probki_adres_q;
    assign probki_dane = probki_dane_q;
    assign START = st_q == START_FIR;
    assign zajety = st_q != IDLE && st_q != ERR;
    assign blad = st_q == ERR;
endmodule

// File: tb/tb_ladowanie_danych.sv
// tb_ladowanie_danych: randomized loads checked by a write scoreboard and per-load summaries
module tb_ladowanie_danych;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic DONE = 1'b0;
    logic blad_kasuj = 1'b0;
    logic wsp_wr, probki_wr, START, zajety, blad;
    logic [4:0] wsp_adres;
    logic [12:0] probki_adres;
    logic [15:0] wsp_dane, probki_dane;
    logic [5:0] wsp;
    logic [13:0] ile_probek;

    always #5 clk = ~clk;

    ladowanie_danych_if #(.DATA_WIDTH(16)) bus ();

    ladowanie_danych dut (
        .clk(clk), .rst(rst), .bus(bus),
        .wsp_wr(wsp_wr), .wsp_adres(wsp_adres), .wsp_dane(wsp_dane),
        .probki_wr(probki_wr), .probki_adres(probki_adres), .probki_dane(probki_dane),
        .wsp(wsp), .ile_probek(ile_probek), .START(START), .DONE(DONE),
        .zajety(zajety), .blad(blad), .blad_kasuj(blad_kasuj)
    );

    typedef struct {
        bit prob;
        int adr;
        int dane;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int checks = 0;
    int failures = 0;
    int n_wsp_wr = 0;
    int n_prob_wr = 0;
    int n_start = 0;
    int last_wsp_adr = -1;
    int last_prob_adr = -1;
    bit acc_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (wsp_wr || probki_wr) begin
            chk("wr_exclusive", int'(wsp_wr && probki_wr), 0);
            chk("wr_latency", int'(acc_prev), 1);
            if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                chk("wr_kind", int'(probki_wr), int'(e.prob));
                chk(e.prob ? "probki_adres" : "wsp_adres",
                    e.prob ? int'(probki_adres) : int'(wsp_adres), e.adr);
                chk(e.prob ? "probki_dane" : "wsp_dane",
                    e.prob ? int'(probki_dane) : int'(wsp_dane), e.dane);
            end
            if (wsp_wr) begin n_wsp_wr++; last_wsp_adr = int'(wsp_adres); end
            if (probki_wr) begin n_prob_wr++; last_prob_adr = int'(probki_adres); end
        end
        if (START) n_start++;
        acc_prev = bus.in_valid && bus.in_ready;
    end

    task automatic send(input logic [15:0] d);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.in_ready && t < 50);
        if (!bus.in_ready) chk("send_timeout", int'(bus.in_ready), 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic gap(input int mode);
        int g = mode == 1 ? 1 : mode == 2 ? int'($urandom_range(0, 2)) : 0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
        chk({tag, "_wsp_wr"}, int'(wsp_wr), 0);
        chk({tag, "_probki_wr"}, int'(probki_wr), 0);
        chk({tag, "_START"}, int'(START), 0);
        chk({tag, "_zajety"}, int'(zajety), 0);
        chk({tag, "_blad"}, int'(blad), 0);
        chk({tag, "_wsp"}, int'(wsp), 0);
        chk({tag, "_ile_probek"}, int'(ile_probek), 0);
        chk({tag, "_wsp_adres"}, int'(wsp_adres), 0);
        chk({tag, "_probki_adres"}, int'(probki_adres), 0);
        chk({tag, "_wsp_dane"}, int'(wsp_dane), 0);
        chk({tag, "_probki_dane"}, int'(probki_dane), 0);
    endtask

    // cval/sval < 0 selects random payload words
    task automatic load(input int n, input int m, input int cval, input int sval,
                        input int gap_mode, input bit done_busy);
        int s0 = n_start;
        int w0 = n_wsp_wr;
        int p0 = n_prob_wr;
        int t = 0;
        int d;
        DONE = done_busy;
        send(16'(n));
        for (int k = 0; k < n; k++) begin
            d = cval < 0 ? int'($urandom_range(0, 65535)) : cval;
            exp_q.push_back('{prob: 1'b0, adr: k, dane: d});
            send(16'(d));
            gap(gap_mode);
        end
        send(16'(m));
        for (int k = 0; k < m; k++) begin
            d = sval < 0 ? int'($urandom_range(0, 65535)) : sval;
            exp_q.push_back('{prob: 1'b1, adr: k, dane: d});
            send(16'(d));
            gap(gap_mode);
        end
        DONE = 1'b0;
        while (n_start == s0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("start_seen", n_start - s0, 1);
        repeat (19) @(posedge clk);
        @(negedge clk);
        chk("start_once", n_start - s0, 1);
        chk("busy_wait_done", int'(zajety), 1);
        chk("wsp", int'(wsp), n);
        chk("ile_probek", int'(ile_probek), m);
        chk("wsp_wr_count", n_wsp_wr - w0, n);
        chk("probki_wr_count", n_prob_wr - p0, m);
        chk("last_wsp_adres", last_wsp_adr, n - 1);
        chk("last_probki_adres", last_prob_adr, m - 1);
        chk("sb_empty", exp_q.size(), 0);
        @(posedge clk);
        #1 DONE = 1'b1;
        @(negedge clk);
        chk("busy_during_done", int'(zajety), 1);
        @(posedge clk);
        #1 DONE = 1'b0;
        @(negedge clk);
        chk("idle_after_done", int'(zajety), 0);
    endtask

    task automatic err_hdr(input int hdr);
        int w0 = n_wsp_wr + n_prob_wr;
        int wsp0 = int'(wsp);
        send(16'(hdr));
        bus.in_valid = 1'b1;
        bus.in_data = 16'h1234;
        @(negedge clk);
        chk("err_blad", int'(blad), 1);
        chk("err_in_ready", int'(bus.in_ready), 0);
        chk("err_zajety", int'(zajety), 0);
        repeat (3) @(negedge clk);
        chk("err_blad_held", int'(blad), 1);
        chk("err_no_writes", n_wsp_wr + n_prob_wr - w0, 0);
        chk("err_wsp_kept", int'(wsp), wsp0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 blad_kasuj = 1'b1;
        @(posedge clk);
        #1 blad_kasuj = 1'b0;
        @(negedge clk);
        chk("err_cleared", int'(blad), 0);
        chk("err_idle", int'(zajety), 0);
    endtask

    initial begin
        int s0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("reset");
        load(3, 3, 16'h4000, 16'h2000, 0, 1'b0);
        err_hdr(0);
        err_hdr(33);
        load(3, 5, -1, -1, 1, 1'b0);
        s0 = n_start;
        send(16'd3);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{prob: 1'b0, adr: k, dane: 100 + k});
            send(16'(100 + k));
        end
        send(16'd3);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{prob: 1'b1, adr: k, dane: 200 + k});
            send(16'(200 + k));
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        repeat (10) @(negedge clk);
        chk("midrst_no_start", n_start - s0, 0);
        chk("midrst_sb_empty", exp_q.size(), 0);
        load(4, 6, -1, -1, 2, 1'b0);
        load(5, 7, -1, -1, 2, 1'b1);
        load(32, 8192, -1, -1, 0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
